// File: rtl/conv_mac_engine.sv
// conv_mac_engine
// Time-multiplexed KxK convolution engine. One window is accepted per
// handshake, then one tap per clock is multiplied against the weights of
// every output channel in parallel. All channel sums are presented together
// on a valid/ready output, with an optional ReLU clamp.
module conv_mac_engine #(
   parameter  int DATA_W = 32,
   parameter  int K      = 5,
   parameter  int NUM_CH = 8,
   parameter  int ACC_W  = 69,
   localparam int TAPS   = K * K,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [CH_W-1:0]            wr_ch,
   input  logic [TAP_W-1:0]           wr_tap,
   input  logic signed [DATA_W-1:0]   wr_data,
   input  logic                       win_valid,
   output logic                       win_ready,
   input  logic [TAPS*DATA_W-1:0]     win_data,
   input  logic                       relu_en,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_CH*ACC_W-1:0]    out_data,
   output logic                       busy
);

   localparam int PROD_W = 2 * DATA_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Full-precision signed product, sign-extended to the accumulator width.
   function automatic logic signed [ACC_W-1:0] mac_term(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic signed [PROD_W-1:0] p;
      p = PROD_W'(a) * PROD_W'(b);
      return ACC_W'(p);
   endfunction

   // Clamp negative sums to zero when the window asked for ReLU.
   function automatic logic signed [ACC_W-1:0] relu(
      input logic signed [ACC_W-1:0] x,
      input logic                    en
   );
      return (en && x[ACC_W-1]) ? '0 : x;
   endfunction

   logic [1:0]                 state;
   logic [TAP_W-1:0]           tap_cnt;
   logic                       last_tap;
   logic                       wr_ok;

   logic signed [DATA_W-1:0]   weight [NUM_CH][TAPS];
   logic signed [DATA_W-1:0]   win_p0 [TAPS];
   logic                       relu_p0;
   logic signed [ACC_W-1:0]    acc_p1 [NUM_CH];
   logic signed [ACC_W-1:0]    acc_nxt_p1 [NUM_CH];

   assign last_tap  = (tap_cnt == TAP_W'(TAPS - 1));
   assign win_ready = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);

   // Weights may only change between windows, and only at in-range addresses.
   assign wr_ok = wr_en && (state == S_IDLE) &&
                  (int'(wr_ch) < NUM_CH) && (int'(wr_tap) < TAPS);

   // Weight store: cleared by reset, written one entry per strobe while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int t = 0; t < TAPS; t++) begin
               weight[c][t] <= '0;
            end
         end
      end else if (wr_ok) begin
         weight[wr_ch][wr_tap] <= wr_data;
      end
   end

   // Next accumulator value per channel for the current tap, ReLU on the last.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         acc_nxt_p1[c] = acc_p1[c] + mac_term(win_p0[tap_cnt], weight[c][tap_cnt]);
         if (last_tap) begin
            acc_nxt_p1[c] = relu(acc_nxt_p1[c], relu_p0);
         end
      end
   end

   // Control FSM plus window latch and accumulators.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         tap_cnt <= '0;
         relu_p0 <= 1'b0;
         for (int t = 0; t < TAPS; t++) begin
            win_p0[t] <= '0;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            acc_p1[c] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (win_valid) begin
                  // window capture stage
                  for (int t = 0; t < TAPS; t++) begin
                     win_p0[t] <= win_data[t*DATA_W +: DATA_W];
                  end
                  relu_p0 <= relu_en;
                  tap_cnt <= '0;
                  for (int c = 0; c < NUM_CH; c++) begin
                     acc_p1[c] <= '0;
                  end
                  state <= S_ACC;
               end
            end
            S_ACC: begin
               // accumulate stage
               for (int c = 0; c < NUM_CH; c++) begin
                  acc_p1[c] <= acc_nxt_p1[c];
               end
               if (last_tap) begin
                  tap_cnt <= '0;
                  state   <= S_DONE;
               end else begin
                  tap_cnt <= tap_cnt + TAP_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Results are driven straight from the accumulator registers.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign out_data[g*ACC_W +: ACC_W] = acc_p1[g];
   end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: reset state, dot products, negative
// sums, ReLU, output back-pressure, dropped weight writes, mid-window reset.
module tb_conv_mac_engine;

   localparam int DATA_W = 32;
   localparam int K      = 5;
   localparam int NUM_CH = 8;
   localparam int ACC_W  = 69;
   localparam int TAPS   = K * K;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       wr_en;
   logic [2:0]                 wr_ch;
   logic [4:0]                 wr_tap;
   logic signed [DATA_W-1:0]   wr_data;
   logic                       win_valid;
   logic                       win_ready;
   logic [TAPS*DATA_W-1:0]     win_data;
   logic                       relu_en;
   logic                       out_valid;
   logic                       out_ready;
   logic [NUM_CH*ACC_W-1:0]    out_data;
   logic                       busy;

   int tests = 0;
   int fails = 0;

   localparam logic signed [ACC_W-1:0] BIG = 69'sd53687091175;

   conv_mac_engine #(
      .DATA_W(DATA_W), .K(K), .NUM_CH(NUM_CH), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_tap(wr_tap), .wr_data(wr_data),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_w(input int ch, input int tap, input logic signed [DATA_W-1:0] d);
      wr_en = 1'b1; wr_ch = 3'(ch); wr_tap = 5'(tap); wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic load_all(input logic signed [DATA_W-1:0] d);
      for (int c = 0; c < NUM_CH; c++)
         for (int t = 0; t < TAPS; t++)
            wr_w(c, t, d);
   endtask

   task automatic fill_win(input logic signed [DATA_W-1:0] v, input bit ramp);
      for (int t = 0; t < TAPS; t++)
         win_data[t*DATA_W +: DATA_W] = ramp ? DATA_W'(t + 1) : v;
   endtask

   task automatic accept(input logic relu);
      relu_en = relu; win_valid = 1'b1;
      tests++;
      if (win_ready !== 1'b1) begin
         fails++;
         $display("FAIL accept_ready: win_ready=%b expected 1", win_ready);
      end
      step();
      win_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 60) begin
         step();
         cyc++;
      end
      if (out_valid !== 1'b1) begin
         tests++; fails++;
         $display("FAIL out_timeout: out_valid=%b after %0d cycles expected 1", out_valid, cyc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      tests++; if (win_ready !== 1'b1) begin fails++; $display("FAIL reset_win_ready: got %b expected 1", win_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
   endtask

   task automatic test_basic();
      int cyc;
      logic signed [ACC_W-1:0] got;
      load_all(32'sd1);
      fill_win(0, 1'b1);
      accept(1'b0);
      tests++; if (busy !== 1'b1 || win_ready !== 1'b0) begin fails++; $display("FAIL basic_busy: busy=%b win_ready=%b expected 1/0", busy, win_ready); end
      wait_out(cyc);
      tests++; if (cyc != 25) begin fails++; $display("FAIL basic_latency: got %0d cycles expected 25", cyc); end
      for (int c = 0; c < NUM_CH; c++) begin
         got = out_data[c*ACC_W +: ACC_W];
         tests++; if (got !== 69'sd325) begin fails++; $display("FAIL basic_ch%0d: got %0d expected 325", c, got); end
      end
      step();
   endtask

   task automatic test_negative(input logic relu);
      int cyc;
      logic signed [ACC_W-1:0] got, exp;
      fill_win(32'sh7FFFFFFF, 1'b0);
      accept(relu);
      step();
      relu_en = ~relu;
      wait_out(cyc);
      for (int c = 0; c < NUM_CH; c++) begin
         got = out_data[c*ACC_W +: ACC_W];
         exp = (c == 3) ? (relu ? 69'sd0 : -BIG) : BIG;
         tests++; if (got !== exp) begin fails++; $display("FAIL neg_relu%0d_ch%0d: got %0d expected %0d", relu, c, got, exp); end
      end
      relu_en = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      int cyc;
      logic signed [ACC_W-1:0] got, exp;
      out_ready = 1'b0;
      fill_win(0, 1'b1);
      accept(1'b0);
      wait_out(cyc);
      fill_win(32'sd2, 1'b0);
      win_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tests++; if (out_valid !== 1'b1 || win_ready !== 1'b0) begin fails++; $display("FAIL hold_flags_%0d: out_valid=%b win_ready=%b expected 1/0", i, out_valid, win_ready); end
         for (int c = 0; c < NUM_CH; c++) begin
            got = out_data[c*ACC_W +: ACC_W];
            exp = (c == 3) ? -69'sd325 : 69'sd325;
            tests++; if (got !== exp) begin fails++; $display("FAIL hold_ch%0d_%0d: got %0d expected %0d", c, i, got, exp); end
         end
         step();
      end
      out_ready = 1'b1;
      step();
      tests++; if (out_valid !== 1'b0 || win_ready !== 1'b1) begin fails++; $display("FAIL release: out_valid=%b win_ready=%b expected 0/1", out_valid, win_ready); end
      got = out_data[3*ACC_W +: ACC_W];
      tests++; if (got !== -69'sd325) begin fails++; $display("FAIL release_hold_data: got %0d expected -325", got); end
      step();
      win_valid = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL next_accept: busy=%b expected 1", busy); end
      wait_out(cyc);
      for (int c = 0; c < NUM_CH; c++) begin
         got = out_data[c*ACC_W +: ACC_W];
         exp = (c == 3) ? -69'sd50 : 69'sd50;
         tests++; if (got !== exp) begin fails++; $display("FAIL next_ch%0d: got %0d expected %0d", c, got, exp); end
      end
      step();
   endtask

   task automatic test_dropped_writes();
      int cyc;
      logic signed [ACC_W-1:0] got, exp;
      load_all(32'sd1);
      wr_w(1, 25, 32'sd7);
      fill_win(32'sd1, 1'b0);
      accept(1'b0);
      step(); step();
      wr_w(0, 0, 32'sd7);
      wait_out(cyc);
      for (int c = 0; c < NUM_CH; c++) begin
         got = out_data[c*ACC_W +: ACC_W];
         tests++; if (got !== 69'sd25) begin fails++; $display("FAIL drop_ch%0d: got %0d expected 25", c, got); end
      end
      step();
      wr_w(0, 0, 32'sd7);
      wr_en = 1'b1; wr_ch = 3'd2; wr_tap = 5'd0; wr_data = 32'sd3;
      accept(1'b0);
      wr_en = 1'b0;
      wait_out(cyc);
      for (int c = 0; c < NUM_CH; c++) begin
         got = out_data[c*ACC_W +: ACC_W];
         exp = (c == 0) ? 69'sd31 : (c == 2) ? 69'sd27 : 69'sd25;
         tests++; if (got !== exp) begin fails++; $display("FAIL idle_write_ch%0d: got %0d expected %0d", c, got, exp); end
      end
      step();
   endtask

   task automatic test_mid_reset();
      int cyc;
      logic signed [ACC_W-1:0] got;
      fill_win(32'sd1, 1'b0);
      accept(1'b0);
      for (int i = 0; i < 12; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++; if (out_valid !== 1'b0 || win_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midrst_flags: out_valid=%b win_ready=%b busy=%b expected 0/1/0", out_valid, win_ready, busy); end
      tests++; if (out_data !== '0) begin fails++; $display("FAIL midrst_data: got %h expected 0", out_data); end
      accept(1'b0);
      wait_out(cyc);
      for (int c = 0; c < NUM_CH; c++) begin
         got = out_data[c*ACC_W +: ACC_W];
         tests++; if (got !== 69'sd0) begin fails++; $display("FAIL midrst_ch%0d: got %0d expected 0", c, got); end
      end
      step();
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_tap = '0; wr_data = '0;
      win_valid = 1'b0; win_data = '0; relu_en = 1'b0; out_ready = 1'b1;
      test_reset();
      test_basic();
      for (int t = 0; t < TAPS; t++) wr_w(3, t, -32'sd1);
      test_negative(1'b0);
      test_negative(1'b1);
      test_backpressure();
      test_dropped_writes();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule
